// File: rtl/sdram_pkg.sv
// Shared definitions for the per-client SDRAM request/finished responder.
package sdram_pkg;

  localparam int unsigned SDRAM_ADDR_W  = 23;
  localparam int unsigned SDRAM_DATA_W  = 32;
  localparam int unsigned SDRAM_TIMEOUT = 1024;
  localparam int unsigned SDRAM_BE_W    = SDRAM_DATA_W / 8;

  // Byteenable for a full-word transfer at the default data width.
  localparam logic [SDRAM_BE_W-1:0] SDRAM_BE_ALL = '1;

  // Responder FSM states.
  typedef enum logic [2:0] {
    IDLE,
    WR_CMD,
    RD_CMD,
    RD_WAIT,
    DONE
  } sdram_state_e;

endpackage

// File: rtl/sdram_client_responder.sv
// Per-client responder: turns a held read/write request into one single-word
// Avalon-MM transfer and answers with registered read data plus a one-cycle
// finished pulse. All outputs are registered.
module sdram_client_responder
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W  = SDRAM_ADDR_W,
  parameter int unsigned DATA_W  = SDRAM_DATA_W,
  parameter int unsigned TIMEOUT = SDRAM_TIMEOUT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                req_read,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_writedata,
  output logic [DATA_W-1:0]   resp_readdata,
  output logic                resp_finished,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic                err_timeout,
  output logic                err_conflict
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  sdram_state_e      state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              is_write, is_write_n;
  logic              stop, stop_n;
  logic              post_done;
  logic              req_valid;

  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic [DATA_W-1:0] rdata_n;
  logic              rd_n, wr_n, fin_n;
  logic              etimeout_n, econflict_n;

  // The in-flight request is still wanted: same type held, same address.
  always_comb begin
    req_valid = (is_write ? req_write : req_read) && (req_addr == avm_address);
  end

  // State and registered outputs; async reset aborts any transfer at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      is_write       <= 1'b0;
      stop           <= 1'b0;
      post_done      <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= '0;
      resp_readdata  <= '0;
      resp_finished  <= 1'b0;
      err_timeout    <= 1'b0;
      err_conflict   <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      is_write       <= is_write_n;
      stop           <= stop_n;
      post_done      <= (state == DONE);
      avm_address    <= addr_n;
      avm_writedata  <= wdata_n;
      avm_read       <= rd_n;
      avm_write      <= wr_n;
      // Reads as zero only while in reset; full-word transfers otherwise.
      avm_byteenable <= '1;
      resp_readdata  <= rdata_n;
      resp_finished  <= fin_n;
      err_timeout    <= etimeout_n;
      err_conflict   <= econflict_n;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    is_write_n  = is_write;
    stop_n      = stop;
    addr_n      = avm_address;
    wdata_n     = avm_writedata;
    rdata_n     = resp_readdata;
    rd_n        = 1'b0;
    wr_n        = 1'b0;
    fin_n       = 1'b0;
    etimeout_n  = err_timeout;
    econflict_n = err_conflict;

    // Any cycle in flight where the client withdrew or changed its request
    // suppresses the final pulse, even if it is restored later.
    if (state != IDLE) begin
      stop_n = stop | ~req_valid;
    end

    unique case (state)
      IDLE: begin
        // The pulse cycle is skipped so the client's still-held old request
        // is not taken as a new transaction.
        if (!post_done) begin
          if (req_write) begin
            addr_n      = req_addr;
            wdata_n     = req_writedata;
            wr_n        = 1'b1;
            is_write_n  = 1'b1;
            stop_n      = 1'b0;
            econflict_n = err_conflict | req_read;
            state_n     = WR_CMD;
          end else if (req_read) begin
            addr_n     = req_addr;
            rd_n       = 1'b1;
            is_write_n = 1'b0;
            stop_n     = 1'b0;
            state_n    = RD_CMD;
          end
        end
      end
      WR_CMD: begin
        if (avm_waitrequest) begin
          wr_n = 1'b1;
        end else begin
          state_n = DONE;
        end
      end
      RD_CMD: begin
        if (avm_waitrequest) begin
          rd_n = 1'b1;
        end else if (avm_readdatavalid) begin
          rdata_n = avm_readdata;
          state_n = DONE;
        end else begin
          cnt_n   = '0;
          state_n = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          rdata_n = avm_readdata;
          state_n = DONE;
        end else if (cnt == CNT_LAST) begin
          rdata_n    = '0;
          etimeout_n = 1'b1;
          state_n    = DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        fin_n   = req_valid & ~stop;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_client_responder.sv
// Self-checking bench for sdram_client_responder: the bench plays both the
// client and the Avalon slave and predicts each transaction's timing and
// results from the request/finished protocol rules.
module tb_sdram_client_responder;

  localparam int TOUT = 1024;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [22:0] req_addr = '0;
  logic [31:0] req_writedata = '0;
  logic [31:0] resp_readdata;
  logic        resp_finished;
  logic [22:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        err_timeout;
  logic        err_conflict;

  int n_assert = 0;
  int n_fail = 0;
  bit exp_timeout = 1'b0;
  bit exp_conflict = 1'b0;
  logic [31:0] mem [int];

  sdram_client_responder #(.ADDR_W(23), .DATA_W(32), .TIMEOUT(TOUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_writedata(req_writedata),
    .resp_readdata(resp_readdata), .resp_finished(resp_finished),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .err_timeout(err_timeout), .err_conflict(err_conflict)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdata"}, 64'(resp_readdata), 64'h0);
    chk({tag, "_fin"}, 64'(resp_finished), 64'h0);
    chk({tag, "_addr"}, 64'(avm_address), 64'h0);
    chk({tag, "_cmd"}, 64'({avm_read, avm_write}), 64'h0);
    chk({tag, "_wdata"}, 64'(avm_writedata), 64'h0);
    chk({tag, "_be"}, 64'(avm_byteenable), 64'h0);
    chk({tag, "_errs"}, 64'({err_timeout, err_conflict}), 64'h0);
  endtask

  // One client transaction, started at an observation point (1 time unit
  // after a rising edge). lat < 0 means the slave never returns read data.
  // chain leaves the request high at the end so the caller can present the
  // next one in the cycle right after the pulse.
  task automatic txn(input bit wr, input bit both, input logic [22:0] a,
                     input logic [31:0] d, input int nwait, input int lat,
                     input bit drop, input bit chain);
    int exp_fin, window, cmd_cyc, acc, fins, fin_at, wait_left, rdv_at;
    logic [31:0] rd_val, exp_rdata;
    exp_fin = wr ? 3 + nwait : ((lat < 0) ? 3 + nwait + TOUT : 3 + nwait + lat);
    window  = chain ? exp_fin + 1 : exp_fin + 3;
    rd_val  = mem.exists(int'(a)) ? mem[int'(a)] : $urandom;
    exp_rdata = (lat < 0) ? 32'h0 : rd_val;
    req_write = wr | both;
    req_read  = ~wr | both;
    req_addr  = a;
    req_writedata = d;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    wait_left = nwait; rdv_at = -1; fins = 0; fin_at = -1; cmd_cyc = 0; acc = 0;
    for (int c = 1; c <= window; c++) begin
      @(posedge i_clk); #1;
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
      if (resp_finished) begin
        fins++;
        if (fin_at < 0) fin_at = c;
      end
      if (avm_read || avm_write) begin
        cmd_cyc++;
        chk("cmd_kind", 64'({avm_write, avm_read}), wr ? 64'h2 : 64'h1);
        chk("cmd_addr", 64'(avm_address), 64'(a));
        chk("cmd_be", 64'(avm_byteenable), 64'hF);
        if (wr) chk("cmd_wdata", 64'(avm_writedata), 64'(d));
        if (wait_left > 0) begin
          avm_waitrequest = 1'b1;
          wait_left--;
        end else begin
          acc++;
          if (!wr && lat >= 0) rdv_at = c + lat;
        end
      end
      if (c == rdv_at) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = rd_val;
      end
      if (drop && c == nwait + 2) req_read = 1'b0;
      if (!chain && fin_at >= 0 && c == fin_at + 1) begin
        req_read = 1'b0;
        req_write = 1'b0;
      end
    end
    if (!chain) begin
      req_read = 1'b0;
      req_write = 1'b0;
    end
    if (wr) mem[int'(a)] = d;
    if (both) exp_conflict = 1'b1;
    if (!wr && lat < 0) exp_timeout = 1'b1;
    chk("cmd_cycles", 64'(cmd_cyc), 64'(nwait + 1));
    chk("cmd_accepts", 64'(acc), 64'h1);
    chk("fin_count", 64'(fins), drop ? 64'h0 : 64'h1);
    chk("fin_cycle", 64'(fin_at), drop ? 64'(-1) : 64'(exp_fin));
    if (!wr) chk("rdata", 64'(resp_readdata), 64'(exp_rdata));
    chk("err_timeout", 64'(err_timeout), 64'(exp_timeout));
    chk("err_conflict", 64'(err_conflict), 64'(exp_conflict));
  endtask

  initial begin
    // Reset values.
    #1 i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 chk_reset_outputs("reset");
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Directed: write with no wait states.
    txn(1'b1, 1'b0, 23'h000010, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0);

    // Directed: read with 3 wait states and read latency 4.
    mem[32'h20] = 32'h12345678;
    txn(1'b0, 1'b0, 23'h000020, 32'h0, 3, 4, 1'b0, 1'b0);

    // Back-to-back reads, second address presented right after the pulse.
    txn(1'b0, 1'b0, 23'h000100, 32'h0, 0, 1, 1'b0, 1'b1);
    txn(1'b0, 1'b0, 23'h000101, 32'h0, 0, 2, 1'b0, 1'b0);

    // Client stops a read before data returns, then a normal request.
    txn(1'b0, 1'b0, 23'h000030, 32'h0, 1, 3, 1'b1, 1'b0);
    txn(1'b1, 1'b0, 23'h000031, 32'hCAFEF00D, 1, 0, 1'b0, 1'b0);
    txn(1'b0, 1'b0, 23'h000031, 32'h0, 0, 0, 1'b0, 1'b0);

    // Read that never receives data.
    txn(1'b0, 1'b0, 23'h000040, 32'h0, 0, -1, 1'b0, 1'b0);

    // Read and write together: the write goes out.
    txn(1'b1, 1'b1, 23'h000055, 32'hA5A55A5A, 0, 0, 1'b0, 1'b0);

    // Randomized traffic over a small address window.
    for (int i = 0; i < 24; i++) begin
      bit wr, drop, chain;
      int lat;
      wr    = 1'($urandom_range(0, 1));
      lat   = int'($urandom_range(0, 5));
      drop  = !wr && lat > 0 && ($urandom_range(0, 3) == 0);
      chain = !drop && i != 23 && ($urandom_range(0, 1) == 1);
      txn(wr, 1'b0, 23'(32'h200 + $urandom_range(0, 7)), $urandom,
          int'($urandom_range(0, 3)), lat, drop, chain);
    end

    // Reset in the middle of a read wait.
    req_read = 1'b1;
    req_addr = 23'h000077;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    repeat (4) begin @(posedge i_clk); #1; end
    chk("pre_reset_errs", 64'({err_timeout, err_conflict}), 64'({exp_timeout, exp_conflict}));
    #2 i_rst_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    req_read = 1'b0;
    exp_timeout = 1'b0;
    exp_conflict = 1'b0;
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Normal service after reset.
    txn(1'b0, 1'b0, 23'h000010, 32'h0, 2, 2, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
